// File: rtl/bht_pkg.sv
// bht_pkg
// Shared types and helpers for the branch-history-table update controller:
//   - bht_state_e    : controller FSM states
//   - bht_upd_t      : queued update entry {idx, taken}
//   - BHT_CNT_RST    : value every 2-bit counter is swept to after reset
//   - bht_sat_next() : saturating 2-bit counter update
// Optional feature macro used by the top: BHT_CTRL_STATS_EN.
package bht_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } bht_state_e;

  // Widest index the entry struct can carry; narrower tables use the low bits.
  localparam int unsigned BHT_IDX_MAX_W = 16;

  localparam logic [1:0] BHT_CNT_RST = 2'b10;

  typedef struct packed {
    logic [BHT_IDX_MAX_W-1:0] idx;
    logic                     taken;
  } bht_upd_t;

  function automatic logic [1:0] bht_sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// bht_upd_fifo
// Small synchronous FIFO holding resolved-branch updates until the
// controller finds a slot to read-modify-write the BHT array.
// Ports:
//   clk, rst_n      clock, async active-low reset (empties the FIFO)
//   push_i, wdata_i push request and entry (ignored when full)
//   pop_i           pop head (ignored when empty)
//   rdata_o         current head entry
//   full_o, empty_o occupancy flags
//   level_o         number of stored entries
// Simultaneous push and pop keeps occupancy; pointers wrap modulo QDEPTH.
module bht_upd_fifo #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned W      = 9,
  localparam int unsigned AW    = $clog2(QDEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0]  mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(QDEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty_o masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl
// Arbitrates a single-ported 2-bit-counter BHT array between fetch lookups
// and queued execute-stage updates, after sweeping every entry to 2'b10.
//
// state | meaning
// INIT  | write BHT_CNT_RST to entry init_cnt, one per cycle
// IDLE  | serve lookups; start an update when allowed
// RD    | read old counter of FIFO head
// WR    | write saturated counter, pop FIFO
//
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   pred_valid/pred_idx -> pred_ready/pred_taken   fetch lookup (0-cycle)
//   upd_valid/upd_idx/upd_taken -> upd_ready      resolved-branch update
//   arr_we/arr_rindex/arr_windex/arr_wdata, arr_rdata  external array
//   init_done, stat_pred_cnt, stat_stall_cnt      status
// Optional macro BHT_CTRL_STATS_EN enables the saturating lookup/stall
// counters; without it both stat outputs are tied to 0.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int unsigned SIZE   = 256,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned IW    = $clog2(SIZE),
  localparam int unsigned QAW   = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pred_valid,
  input  logic [IW-1:0] pred_idx,
  output logic          pred_ready,
  output logic          pred_taken,
  input  logic          upd_valid,
  input  logic [IW-1:0] upd_idx,
  input  logic          upd_taken,
  output logic          upd_ready,
  output logic          arr_we,
  output logic [IW-1:0] arr_rindex,
  output logic [IW-1:0] arr_windex,
  output logic [1:0]    arr_wdata,
  input  logic [1:0]    arr_rdata,
  output logic          init_done,
  output logic [31:0]   stat_pred_cnt,
  output logic [31:0]   stat_stall_cnt
);

  bht_state_e     state_q, state_d;
  logic [IW-1:0]  init_cnt_q, init_cnt_d;
  logic [1:0]     old_q;
  logic           init_done_q;
  logic           arr_we_c;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IW:0]    fifo_wdata, fifo_rdata;
  logic [QAW:0]   fifo_level;
  bht_upd_t       head;
  logic [IW-1:0]  head_idx;
  logic [BHT_IDX_MAX_W-1:0] head_idx_unused;
  logic           stays_nonempty;

  assign upd_ready  = (state_q != ST_INIT) & ~fifo_full;
  assign fifo_push  = upd_valid & upd_ready;
  assign fifo_wdata = {upd_idx, upd_taken};

  bht_upd_fifo #(
    .QDEPTH (QDEPTH),
    .W      (IW + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign head.idx        = BHT_IDX_MAX_W'(fifo_rdata[IW:1]);
  assign head.taken      = fifo_rdata[0];
  assign head_idx        = head.idx[IW-1:0];
  assign head_idx_unused = head.idx;

  // After this WR's pop, is anything left (a same-cycle push counts)?
  assign stays_nonempty = (fifo_level > (QAW+1)'(1)) | fifo_push;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pred_ready = 1'b0;
    arr_we_c   = 1'b0;
    arr_rindex = pred_idx;
    arr_windex = init_cnt_q;
    arr_wdata  = BHT_CNT_RST;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_INIT: begin
        arr_we_c   = 1'b1;
        init_cnt_d = init_cnt_q + IW'(1);
        if (init_cnt_q == IW'(SIZE - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // A full queue wins over lookups so updates cannot starve.
        if (!fifo_empty && (!pred_valid || fifo_full)) state_d = ST_RD;
        else pred_ready = 1'b1;
      end
      ST_RD: begin
        arr_rindex = head_idx;
        state_d    = ST_WR;
      end
      ST_WR: begin
        // Array read bypasses wdata while writing, so lookups stay blocked.
        arr_rindex = head_idx;
        arr_we_c   = 1'b1;
        arr_windex = head_idx;
        arr_wdata  = bht_sat_next(old_q, head.taken);
        fifo_pop   = 1'b1;
        if (stays_nonempty && (!pred_valid || fifo_full)) state_d = ST_RD;
        else state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      old_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_q | (state_q != ST_INIT);
      if (state_q == ST_RD) old_q <= arr_rdata;
    end
  end

  // State sits in INIT while reset is held; keep the array untouched then.
  assign arr_we     = arr_we_c & rst_n;
  assign pred_taken = arr_rdata[1];
  assign init_done  = init_done_q;

`ifdef BHT_CTRL_STATS_EN
  logic [31:0] stat_pred_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (pred_valid && pred_ready && (stat_pred_q != '1))
        stat_pred_q <= stat_pred_q + 32'd1;
      if (pred_valid && !pred_ready && (state_q != ST_INIT) && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_pred_cnt  = stat_pred_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  assign stat_pred_cnt  = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Testbench for bht_update_ctrl: models the BHT array, predicts every array
// write from accepted updates (scoreboard queue) and checks lookups against
// the committed counter values.
module tb_bht_update_ctrl;

  localparam int SIZE = 256;
  localparam int IW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_valid, pred_ready, pred_taken;
  logic [IW-1:0] pred_idx;
  logic          upd_valid, upd_taken, upd_ready;
  logic [IW-1:0] upd_idx;
  logic          arr_we;
  logic [IW-1:0] arr_rindex, arr_windex;
  logic [1:0]    arr_wdata, arr_rdata;
  logic          init_done;
  logic [31:0]   stat_pred_cnt, stat_stall_cnt;

  bht_update_ctrl #(.SIZE(SIZE), .QDEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_idx       (pred_idx),
    .pred_ready     (pred_ready),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_ready      (upd_ready),
    .arr_we         (arr_we),
    .arr_rindex     (arr_rindex),
    .arr_windex     (arr_windex),
    .arr_wdata      (arr_wdata),
    .arr_rdata      (arr_rdata),
    .init_done      (init_done),
    .stat_pred_cnt  (stat_pred_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  always #5 clk = ~clk;

  // BHT array model: combinational read with write bypass.
  logic [1:0] mem [SIZE];
  assign arr_rdata = arr_we ? arr_wdata : mem[arr_rindex];
  always @(posedge clk) if (arr_we) mem[arr_windex] <= arr_wdata;

  typedef struct {
    int         idx;
    logic [1:0] data;
  } wr_exp_t;

  wr_exp_t    sb[$];
  logic [1:0] model_acc [SIZE];  // value after all accepted updates
  logic [1:0] model_arr [SIZE];  // value after writes seen so far
  int n_cmp = 0, n_mis = 0;
  int init_exp, init_writes, exp_pred, exp_stall;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] sat_ref(input logic [1:0] c, input logic t);
    int v;
    v = t ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < SIZE; i++) begin
        model_acc[i] = 2'b10;
        model_arr[i] = 2'b10;
      end
      init_exp = 0; init_writes = 0; exp_pred = 0; exp_stall = 0;
    end else begin
      if (arr_we) begin
        if (!init_done) begin
          chk("init_idx", 32'(arr_windex), init_exp);
          chk("init_data", 32'(arr_wdata), 32'd2);
          init_exp++;
          init_writes++;
        end else if (sb.size() == 0) begin
          chk("unexpected_wr", 32'(arr_we), 32'd0);
        end else begin
          wr_exp_t e;
          e = sb.pop_front();
          chk("wr_idx", 32'(arr_windex), e.idx);
          chk("wr_data", 32'(arr_wdata), 32'(e.data));
          model_arr[e.idx] = e.data;
        end
      end
      if (pred_valid && pred_ready) begin
        chk("pred_taken", 32'(pred_taken), 32'(model_arr[pred_idx][1]));
        exp_pred++;
      end else if (pred_valid && init_done) begin
        exp_stall++;
      end
      if (upd_valid && upd_ready) begin
        wr_exp_t e;
        e.idx  = int'(upd_idx);
        e.data = sat_ref(model_acc[upd_idx], upd_taken);
        model_acc[upd_idx] = e.data;
        sb.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    int n;
    cyc();
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("init_latency", n, 257);
    chk("init_wr_cnt", init_writes, 256);
    cyc();
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) cyc();
    chk("drain", sb.size(), 0);
    repeat (2) cyc();
  endtask

  task automatic push_upd(input logic [IW-1:0] idx, input logic t, input int cnt);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    repeat (cnt) cyc();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [IW-1:0] idx, input logic exp);
    pred_valid = 1'b1;
    pred_idx   = idx;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(pred_ready), 32'd1);
    chk(tag, 32'(pred_taken), 32'(exp));
    cyc();
    pred_valid = 1'b0;
  endtask

  logic [IW-1:0] q_idx [4] = '{8'd9, 8'd9, 8'd10, 8'd11};
  logic          q_tk  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int k, guard, st;
    bit saw_wr;
    rst_n = 1'b0; pred_valid = 1'b0; pred_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_pred_ready", 32'(pred_ready), 0);
    chk("rst_upd_ready", 32'(upd_ready), 0);
    chk("rst_arr_we", 32'(arr_we), 0);
    chk("rst_stat_pred", stat_pred_cnt, 0);
    chk("rst_stat_stall", stat_stall_cnt, 0);

    do_init();
    @(negedge clk);
    chk("idle_pred_ready", 32'(pred_ready), 1);
    chk("idle_upd_ready", 32'(upd_ready), 1);
    cyc();

    // idx 5 taken twice: 2'b11 then saturated 2'b11
    push_upd(8'd5, 1'b1, 2);
    wait_drain(50);
    lookup("lkp5", 8'd5, 1'b1);

    // idx 7 not taken three times: 01, 00, 00
    push_upd(8'd7, 1'b0, 3);
    wait_drain(50);
    lookup("lkp7", 8'd7, 1'b0);

    // continuous lookups while four updates fill the queue
    pred_valid = 1'b1;
    upd_valid  = 1'b1;
    k = 0; guard = 0;
    while (k < 4 && guard < 20) begin
      upd_idx   = q_idx[k];
      upd_taken = q_tk[k];
      pred_idx  = IW'($urandom_range(0, 15));
      @(negedge clk);
      if (upd_ready) k++;
      cyc();
      guard++;
    end
    upd_valid = 1'b0;
    chk("fill_accepts", k, 4);
    @(negedge clk);
    chk("full_upd_ready", 32'(upd_ready), 0);
    chk("full_pred_ready", 32'(pred_ready), 0);
    st = 0;
    while (!pred_ready && st < 20) begin
      st++;
      cyc();
      pred_idx = IW'($urandom_range(0, 15));
      @(negedge clk);
    end
    chk("drain_stall_cycles", st, 5);
    chk("nonfull_upd_ready", 32'(upd_ready), 1);
    chk("sb_left", sb.size(), 2);
    cyc();
    pred_valid = 1'b0;
    wait_drain(50);

    // reset in the middle of a WR cycle
    upd_valid = 1'b1; upd_idx = 8'd20; upd_taken = 1'b1;
    repeat (3) cyc();
    upd_valid = 1'b0;
    saw_wr = 1'b0;
    for (int i = 0; i < 20 && !saw_wr; i++) begin
      @(negedge clk);
      if (arr_we) saw_wr = 1'b1;
    end
    chk("wr_seen", 32'(saw_wr), 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_arr_we", 32'(arr_we), 0);
    chk("rst2_upd_ready", 32'(upd_ready), 0);
    chk("rst2_init_done", 32'(init_done), 0);
    do_init();
    repeat (20) cyc();
    lookup("lkp20", 8'd20, 1'b1);

    // random traffic on a small index range
    for (int i = 0; i < 300; i++) begin
      pred_valid = 1'($urandom_range(0, 1));
      pred_idx   = IW'($urandom_range(0, 15));
      upd_valid  = 1'($urandom_range(0, 1));
      upd_idx    = IW'($urandom_range(0, 15));
      upd_taken  = 1'($urandom_range(0, 1));
      cyc();
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    wait_drain(100);

`ifdef BHT_CTRL_STATS_EN
    chk("stat_pred", stat_pred_cnt, exp_pred);
    chk("stat_stall", stat_stall_cnt, exp_stall);
`else
    chk("stat_pred_off", stat_pred_cnt, 0);
    chk("stat_stall_off", stat_stall_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 256, number of BHT entries; IW = clog2(SIZE).
REQ-002 SHALL have parameter QDEPTH, default 4, update-queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports pred_valid in 1, pred_idx in IW, pred_ready out 1, pred_taken out 1: fetch lookup; pred_taken valid in any cycle with pred_valid & pred_ready.
REQ-006 SHALL have ports upd_valid in 1, upd_idx in IW, upd_taken in 1, upd_ready out 1: execute-stage resolved-branch update.
REQ-007 SHALL have array-side ports arr_we out 1, arr_rindex out IW, arr_windex out IW, arr_wdata out 2, arr_rdata in 2: array read is combinational, and arr_rdata equals arr_wdata whenever arr_we=1, regardless of index.
REQ-008 SHALL have ports init_done out 1, stat_pred_cnt out 32, stat_stall_cnt out 32.

Function
REQ-009 SHALL implement FSM states INIT, IDLE, RD, WR.
REQ-010 INIT: SHALL write 2'b10 to entries 0..SIZE-1, one per cycle (arr_we=1, arr_windex=init counter), then go to IDLE; init_done=1 from the next cycle on.
REQ-011 SHALL hold pred_ready=0 and upd_ready=0 in INIT.
REQ-012 SHALL buffer accepted updates in a FIFO of QDEPTH {idx,taken}; upd_ready = !full outside INIT; push on upd_valid & upd_ready.
REQ-013 IDLE->RD when FIFO non-empty and (pred_valid=0 or FIFO full); else stay in IDLE.
REQ-014 RD: SHALL drive arr_rindex=head idx and register arr_rdata as old counter; pred_ready=0; next state WR.
REQ-015 WR: SHALL write the saturating next counter to head idx (taken: min(c+1,3); not taken: max(c-1,0)), pop the FIFO, and set pred_ready=0 (array read bypass corrupts reads while writing); then go to RD if FIFO stays non-empty and (pred_valid=0 or the FIFO was full at the start of WR), else IDLE.
REQ-016 IDLE: pred_ready=1 unless the transition to RD is taken; arr_rindex=pred_idx; pred_taken=arr_rdata[1], 0-cycle latency.
REQ-017 Full FIFO SHALL give updates priority over predictions (prevents update starvation); otherwise predictions win.
REQ-018 Simultaneous push and pop in WR SHALL be legal; occupancy unchanged; pointers wrap modulo QDEPTH.
REQ-019 Updates SHALL be applied in acceptance order; same-index back-to-back updates SHALL compound (second reads the first's written value).
REQ-020 arr_we SHALL be 1 only in INIT and WR.

Reset
REQ-021 On rst_n=0: state=INIT, init counter=0, FIFO empty, init_done=0, pred_ready=0, upd_ready=0, arr_we=0, stats=0; an in-flight RD/WR update is discarded.
REQ-022 Reset deassertion SHALL restart the full INIT sweep.

Configuration
REQ-023 With BHT_CTRL_STATS_EN defined: stat_pred_cnt increments on each pred_valid & pred_ready cycle; stat_stall_cnt increments on each pred_valid & !pred_ready cycle outside INIT; both saturate at 2^32-1.
REQ-024 Without BHT_CTRL_STATS_EN: both stat outputs constant 0, no counter flops.

Structure
REQ-025 Shared package bht_pkg SHALL hold the FSM state enum, the update-entry struct {idx, taken}, the counter reset constant 2'b10, and the saturating-update function.
REQ-026 FIFO SHALL be sub-module bht_upd_fifo (QDEPTH, entry width params, push/pop/full/empty).

Verification
REQ-027 Reset, SIZE=256: init_done rises 257 cycles after rst_n deassertion; arr_we=1 for exactly 256 cycles with windex 0..255, wdata=2'b10.
REQ-028 After init, update idx=5 taken twice with no pred_valid -> writes 2'b11 then 2'b11 (saturated); a lookup of idx 5 then gives pred_taken=1.
REQ-029 Three not-taken updates to idx 7 -> writes 2'b01, 2'b00, 2'b00; lookup gives pred_taken=0.
REQ-030 Continuous pred_valid plus 4 queued updates -> upd_ready=0 while full, pred_ready=0 during RD/WR drain, all 4 updates written in order, pred_ready returns to 1 once the FIFO is no longer full.
REQ-031 rst_n pulsed low during WR -> no further arr_we except INIT writes, FIFO empty, INIT restarts at index 0.
REQ-032 With BHT_CTRL_STATS_EN: 10 accepted lookups plus 3 stalled cycles -> stat_pred_cnt=10, stat_stall_cnt=3; without the macro, both read 0.
